fetch_prefetch_unit: RTL and testbench

Instruction fetch stage placed directly upstream of the single-cycle datapath. It owns the fetch program counter and drives a word-addressed instruction memory through a req/ack handshake. Returned words are buffered with their PCs in a small prefetch FIFO, and the decoder consumes them through a valid/ready interface. A taken branch from the datapath redirects fetch and flushes every buffered word.

---
 rtl/fetch_prefetch_unit.sv | 184 ++++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
// Instruction fetch stage: owns the fetch PC, issues word fetches over a
// req/ack handshake, buffers returned words with their PCs in a small
// prefetch FIFO and hands them to the decoder through valid/ready.
// A taken branch redirects fetch and flushes everything buffered.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_target,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic                    imem_ack,
  input  logic [31:0]             imem_rdata,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [31:0]             instru,
  output logic [31:0]             instr_pc,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Fetch control state
  state_e         state_q;
  logic [31:0]    fetch_pc_q;
  logic           imem_req_q;
  logic [31:0]    imem_addr_q;

  // Prefetch FIFO state; each entry is {instruction, pc}
  logic [63:0]    mem_q [DEPTH];
  logic [AW-1:0]  wptr_q;
  logic [AW-1:0]  rptr_q;
  logic [CW-1:0]  count_q;
  logic           valid_q;
  logic [31:0]    instru_q;
  logic [31:0]    instr_pc_q;

  // Combinational event decode and next-state values
  logic           xfer;
  logic           pop;
  logic           flush;
  logic           push;
  logic [CW-1:0]  count_pop;
  logic [CW-1:0]  count_d;
  logic [AW-1:0]  rptr_d;
  logic [AW-1:0]  wptr_d;
  logic [63:0]    head_d;
  logic [31:0]    pc_inc;
  logic [31:0]    target;

  // Decode this cycle's transfer/pop/flush and derive next occupancy and head
  always_comb begin
    xfer      = imem_req_q & imem_ack;
    pop       = valid_q & instr_ready;
    flush     = branch_taken;
    // Only a word fetched in REQ is kept; DRAIN returns and flushed
    // transfers are dropped.
    push      = (state_q == S_REQ) & xfer & ~flush;
    count_pop = count_q - CW'(pop);
    count_d   = flush ? '0 : (count_pop + CW'(push));
    rptr_d    = rptr_q + AW'(pop);
    wptr_d    = wptr_q + AW'(push);
    pc_inc    = fetch_pc_q + 32'd4;
    target    = {branch_target[31:2], 2'b00};
    // When the FIFO drains to empty and refills on the same edge, the new
    // head is the word arriving now rather than anything in storage.
    if (push && (rptr_d == wptr_q)) begin
      head_d = {imem_rdata, fetch_pc_q};
    end else begin
      head_d = mem_q[rptr_d];
    end
  end

  // Fetch FSM: state, fetch PC and the registered memory request outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= target;
            imem_req_q  <= 1'b1;
            imem_addr_q <= target;
          end else if (count_pop < DEPTH_C) begin
            state_q     <= S_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_pc_q;
          end
        end
        S_REQ: begin
          if (flush) begin
            fetch_pc_q <= target;
            if (xfer) begin
              // Outstanding request just completed; restart at the target.
              imem_addr_q <= target;
            end else begin
              // Request cannot be withdrawn: keep it on the old address and
              // throw the returning word away.
              state_q <= S_DRAIN;
            end
          end else if (xfer) begin
            fetch_pc_q  <= pc_inc;
            imem_addr_q <= pc_inc;
            if (count_d >= DEPTH_C) begin
              state_q    <= S_IDLE;
              imem_req_q <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (flush) begin
            fetch_pc_q <= target;
          end else if (xfer) begin
            state_q     <= S_REQ;
            imem_addr_q <= fetch_pc_q;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage write; no reset needed since occupancy qualifies the data
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {imem_rdata, fetch_pc_q};
    end
  end

  // FIFO pointers, occupancy and registered head outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      instru_q   <= '0;
      instr_pc_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= (count_d != '0);
      // Head outputs hold their last value while the FIFO is empty.
      if (count_d != '0) begin
        instru_q   <= head_d[63:32];
        instr_pc_q <= head_d[31:0];
      end
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = valid_q;
  assign instru      = instru_q;
  assign instr_pc    = instr_pc_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: zero-wait memory model
// returning addr ^ 32'hA5A5_0000, scoreboard of expected fetch PCs, and
// directed scenario tasks.
module tb_fetch_prefetch_unit;

  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instru;
  logic [31:0] instr_pc;
  logic [2:0]  fifo_count;

  logic        w_branch_taken = 1'b0;
  logic [31:0] w_branch_target = 32'h0;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_ack = 1'b1;
  logic [31:0] w_imem_rdata;
  logic        w_instr_valid;
  logic        w_instr_ready = 1'b1;
  logic [31:0] w_instru;
  logic [31:0] w_instr_pc;
  logic [2:0]  w_fifo_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  assign imem_rdata   = imem_addr ^ XORK;
  assign w_imem_rdata = w_imem_addr ^ XORK;

  fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instru(instru),
    .instr_pc(instr_pc), .fifo_count(fifo_count)
  );

  fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .branch_taken(w_branch_taken), .branch_target(w_branch_target),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instru(w_instru),
    .instr_pc(w_instr_pc), .fifo_count(w_fifo_count)
  );

  // Scoreboard: every pop of the main DUT is compared against the expected stream
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (fifo_count > 3'd4) begin
        errors++; $display("FAIL overflow: fifo_count %0d exceeds 4", fifo_count);
      end
      if (imem_req && (imem_addr[1:0] != 2'b00)) begin
        errors++; $display("FAIL align: imem_addr %h not word aligned", imem_addr);
      end
      if (!branch_taken && instr_valid && instr_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL sb_empty: pop of pc %h with no expected entry", instr_pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (instr_pc !== exp_pc || instru !== (exp_pc ^ XORK)) begin
            errors++;
            $display("FAIL sb_pop: got pc %h instr %h, expected pc %h instr %h",
                     instr_pc, instru, exp_pc, exp_pc ^ XORK);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_load(input logic [31:0] base);
    sb_q.delete();
    for (int k = 0; k < 64; k++) sb_q.push_back(base + 32'(4 * k));
  endtask

  task automatic do_reset(input logic rdy, input logic ack);
    rst = 1'b0;
    branch_taken = 1'b0;
    instr_ready = rdy;
    imem_ack = ack;
    step();
    step();
    sb_load(32'h0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
    checks++; if (instru !== 32'h0) begin errors++; $display("FAIL rst_instru: got %h expected 0", instru); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", instr_pc); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
    checks++; if (w_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_waddr: got %h expected fffffffc", w_imem_addr); end
    imem_ack = 1'b1;
    step();
    step();
    checks++; if (imem_req !== 1'b0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL rst_hold: got req %b count %0d expected 0 0", imem_req, fifo_count);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1, 1'b1);
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL stream_c1: got req %b addr %h valid %b expected 1 0 0", imem_req, imem_addr, instr_valid);
    end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instru !== XORK) begin
      errors++; $display("FAIL stream_c2: got valid %b pc %h instr %h expected 1 0 %h", instr_valid, instr_pc, instru, XORK);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || fifo_count !== 3'd1) begin
        errors++;
        $display("FAIL stream_seq: got valid %b pc %h count %0d expected 1 %h 1", instr_valid, instr_pc, fifo_count, 32'(4 * k));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step();
    checks++; if (fifo_count !== 3'd4 || imem_req !== 1'b0) begin
      errors++; $display("FAIL bp_full: got count %0d req %b expected 4 0", fifo_count, imem_req);
    end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL bp_head: got valid %b pc %h expected 1 0", instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    step();
    checks++; if (fifo_count !== 3'd3 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL bp_resume: got count %0d req %b addr %h expected 3 1 10", fifo_count, imem_req, imem_addr);
    end
    for (int k = 0; k < 6; k++) step();
    checks++; if (instr_pc !== 32'h1C || fifo_count !== 3'd3) begin
      errors++; $display("FAIL bp_drain: got pc %h count %0d expected 1c 3", instr_pc, fifo_count);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset(1'b1, 1'b1);
    step();
    step();
    step();
    imem_ack = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL rd_pend: got req %b addr %h expected 1 8", imem_req, imem_addr);
    end
    branch_taken = 1'b1;
    branch_target = 32'h103;
    sb_load(32'h100);
    step();
    branch_taken = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || fifo_count !== 3'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rd_drain: got req %b addr %h count %0d valid %b expected 1 8 0 0", imem_req, imem_addr, fifo_count, instr_valid);
    end
    step();
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL rd_hold: got addr %h expected 8", imem_addr); end
    imem_ack = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rd_tgt: got addr %h valid %b expected 100 0", imem_addr, instr_valid);
    end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instru !== (32'h100 ^ XORK)) begin
      errors++; $display("FAIL rd_first: got valid %b pc %h instr %h expected 1 100 %h", instr_valid, instr_pc, instru, 32'h100 ^ XORK);
    end
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_simultaneous();
    do_reset(1'b0, 1'b1);
    step();
    step();
    step();
    checks++; if (fifo_count !== 3'd2 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL sim_pre: got count %0d addr %h expected 2 8", fifo_count, imem_addr);
    end
    instr_ready = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h200;
    sb_load(32'h200);
    step();
    branch_taken = 1'b0;
    checks++; if (fifo_count !== 3'd0 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL sim_flush: got count %0d valid %b req %b addr %h expected 0 0 1 200", fifo_count, instr_valid, imem_req, imem_addr);
    end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
      errors++; $display("FAIL sim_first: got valid %b pc %h expected 1 200", instr_valid, instr_pc);
    end
    step();
    checks++; if (instr_pc !== 32'h204) begin errors++; $display("FAIL sim_next: got pc %h expected 204", instr_pc); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1, 1'b1);
    step();
    checks++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_req: got req %b addr %h expected 1 fffffffc", w_imem_req, w_imem_addr);
    end
    step();
    checks++; if (w_instr_pc !== 32'hFFFF_FFFC || w_instru !== (32'hFFFF_FFFC ^ XORK)) begin
      errors++; $display("FAIL wrap_top: got pc %h instr %h expected fffffffc %h", w_instr_pc, w_instru, 32'hFFFF_FFFC ^ XORK);
    end
    step();
    checks++; if (w_instr_pc !== 32'h0 || w_instru !== XORK) begin
      errors++; $display("FAIL wrap_zero: got pc %h instr %h expected 0 %h", w_instr_pc, w_instru, XORK);
    end
    step();
    checks++; if (w_instr_pc !== 32'h4) begin errors++; $display("FAIL wrap_four: got pc %h expected 4", w_instr_pc); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step();
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL ar_pre: got count %0d expected 3", fifo_count); end
    #2 rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL ar_ctl: got req %b addr %h valid %b expected 0 0 0", imem_req, imem_addr, instr_valid);
    end
    checks++; if (instru !== 32'h0 || instr_pc !== 32'h0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL ar_data: got instr %h pc %h count %0d expected 0 0 0", instru, instr_pc, fifo_count);
    end
    step();
    checks++; if (imem_req !== 1'b0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL ar_ack_ign: got req %b count %0d expected 0 0", imem_req, fifo_count);
    end
    sb_load(32'h0);
    rst = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL ar_restart: got req %b addr %h expected 1 0", imem_req, imem_addr);
    end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL ar_first: got valid %b pc %h expected 1 0", instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    step();
    checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL ar_second: got pc %h expected 4", instr_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stall();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    for (int k = 0; k < 4; k++) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
